// File: rtl/axi_master_pipelined_if.sv
// Request/response and AXI4 signal bundle for axi_master_pipelined.
// The master modport is the bridge's view; slave is the requester-plus-interconnect view.
interface axi_master_pipelined_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_size;
  logic [DATA_WIDTH-1:0] req_data;
  logic [STRB_WIDTH-1:0] req_be;

  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_err;
  logic                  wr_done;
  logic                  wr_err;
  logic                  idle;

  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [2:0]            m_axi_arsize;
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [7:0]            m_axi_arlen;
  logic [1:0]            m_axi_arburst;

  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic [ID_WIDTH-1:0]   m_axi_rid;

  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [2:0]            m_axi_awsize;
  logic [ID_WIDTH-1:0]   m_axi_awid;
  logic [7:0]            m_axi_awlen;
  logic [1:0]            m_axi_awburst;

  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;

  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [1:0]            m_axi_bresp;
  logic [ID_WIDTH-1:0]   m_axi_bid;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_data, req_be,
    output req_ready, rd_valid, rd_data, rd_err, wr_done, wr_err, idle,
    output m_axi_arvalid, m_axi_araddr, m_axi_arsize, m_axi_arid, m_axi_arlen, m_axi_arburst,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid,
    output m_axi_rready,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awsize, m_axi_awid, m_axi_awlen, m_axi_awburst,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp, m_axi_bid,
    output m_axi_bready
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_data, req_be,
    input  req_ready, rd_valid, rd_data, rd_err, wr_done, wr_err, idle,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arsize, m_axi_arid, m_axi_arlen, m_axi_arburst,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid,
    input  m_axi_rready,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awsize, m_axi_awid, m_axi_awlen, m_axi_awburst,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp, m_axi_bid,
    input  m_axi_bready
  );
endinterface

// File: rtl/axi_master_pipelined.sv
// Single-beat AXI4 master for a load/store unit: up to MAX_OUTSTANDING reads+writes
// in flight, independent AW/W issue, registered read data and B/R error reporting.
module axi_master_pipelined #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_master_pipelined_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]      count_q, count_d;
  logic                  arvalid_q, arvalid_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [2:0]            awsize_q, awsize_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  rd_valid_q, rd_err_q, wr_done_q, wr_err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic ar_free, aw_free, w_free;
  logic r_done, b_done, req_ready, accept;
  int   count_sum;

  assign ar_free = !arvalid_q || bus.m_axi_arready;
  assign aw_free = !awvalid_q || bus.m_axi_awready;
  assign w_free  = !wvalid_q  || bus.m_axi_wready;
  assign r_done  = bus.m_axi_rvalid && bus.m_axi_rlast;
  assign b_done  = bus.m_axi_bvalid;

  // A completion arriving this cycle frees a slot for an accept in the same cycle.
  assign req_ready = ((count_q < MAX_CNT) || r_done || b_done) && ar_free && aw_free && w_free;
  assign accept    = bus.req_valid && req_ready;

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    arvalid_d = arvalid_q && !bus.m_axi_arready;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    awvalid_d = awvalid_q && !bus.m_axi_awready;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wvalid_d  = wvalid_q && !bus.m_axi_wready;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (accept && !bus.req_we) begin
      arvalid_d = 1'b1;
      araddr_d  = bus.req_addr;
      arsize_d  = bus.req_size;
    end
    if (accept && bus.req_we) begin
      awvalid_d = 1'b1;
      awaddr_d  = bus.req_addr;
      awsize_d  = bus.req_size;
      wvalid_d  = 1'b1;
      wdata_d   = bus.req_data;
      wstrb_d   = bus.req_be;
    end
  end

  // Unsolicited completions saturate at zero rather than wrapping.
  always_comb begin
    count_sum = int'(count_q) + int'(accept) - int'(r_done) - int'(b_done);
    if (count_sum < 0) count_sum = 0;
    count_d = CNT_W'(count_sum);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      arvalid_q  <= arvalid_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      rd_valid_q <= bus.m_axi_rvalid;
      rd_err_q   <= bus.m_axi_rvalid && bus.m_axi_rresp[1];
      wr_done_q  <= bus.m_axi_bvalid;
      wr_err_q   <= bus.m_axi_bvalid && bus.m_axi_bresp[1];
    end
  end

  // NOTE: payload and read-data registers are deliberately unreset; they are only
  // observed while their valid is high, so a reset would add fan-out for nothing.
  always_ff @(posedge clk) begin
    araddr_q  <= araddr_d;
    arsize_q  <= arsize_d;
    awaddr_q  <= awaddr_d;
    awsize_q  <= awsize_d;
    wdata_q   <= wdata_d;
    wstrb_q   <= wstrb_d;
    if (bus.m_axi_rvalid) rd_data_q <= bus.m_axi_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (count_q <= MAX_CNT);
      assert (!(r_done || b_done) || count_q != '0);
      assert (int'(count_q) + int'(accept) >= int'(r_done) + int'(b_done));
    end
  end

  logic unused_bits;
  assign unused_bits = &{bus.m_axi_rresp[0], bus.m_axi_bresp[0], bus.m_axi_rid, bus.m_axi_bid};

  assign bus.req_ready     = req_ready;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_err        = rd_err_q;
  assign bus.wr_done       = wr_done_q;
  assign bus.wr_err        = wr_err_q;
  assign bus.idle          = (count_q == '0) && !arvalid_q && !awvalid_q && !wvalid_q;

  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arsize  = arsize_q;
  assign bus.m_axi_arid    = '0;
  assign bus.m_axi_arlen   = 8'd0;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_rready  = 1'b1;

  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_awaddr  = awaddr_q;
  assign bus.m_axi_awsize  = awsize_q;
  assign bus.m_axi_awid    = '0;
  assign bus.m_axi_awlen   = 8'd0;
  assign bus.m_axi_awburst = 2'b01;

  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = wstrb_q;
  assign bus.m_axi_wlast   = wvalid_q;
  assign bus.m_axi_bready  = 1'b1;
endmodule

// File: tb/tb_axi_master_pipelined.sv
// Directed bench for axi_master_pipelined: reset, single read, outstanding limit,
// split AW/W write with error, simultaneous completions, async reset and AR back-pressure.
module tb_axi_master_pipelined;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int MO = 4;

  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  axi_master_pipelined_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_master_pipelined #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst               = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_addr      = '0;
    bus.req_size      = 3'd2;
    bus.req_data      = '0;
    bus.req_be        = '0;
    bus.m_axi_arready = 1'b1;
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    bus.m_axi_rvalid  = 1'b1;
    bus.m_axi_rdata   = 32'h1234_5678;
    bus.m_axi_rresp   = 2'b10;
    bus.m_axi_rlast   = 1'b1;
    bus.m_axi_rid     = '0;
    bus.m_axi_bvalid  = 1'b1;
    bus.m_axi_bresp   = 2'b10;
    bus.m_axi_bid     = '0;

    // Reset held with bus valids asserted
    repeat (3) step();
    check("rst_arvalid",  bus.m_axi_arvalid, 0);
    check("rst_awvalid",  bus.m_axi_awvalid, 0);
    check("rst_wvalid",   bus.m_axi_wvalid, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_wr_done",  bus.wr_done, 0);
    check("rst_idle",     bus.idle, 1);
    check("rst_ready",    bus.req_ready, 1);
    check("const_arlen",  {bus.m_axi_arlen, bus.m_axi_arburst, bus.m_axi_arid}, 64'b00000000_01_0);
    check("const_awlen",  {bus.m_axi_awlen, bus.m_axi_awburst, bus.m_axi_awid}, 64'b00000000_01_0);
    check("const_rbready", {bus.m_axi_rready, bus.m_axi_bready}, 2'b11);
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_bvalid = 1'b0;
    bus.m_axi_rresp  = 2'b00;
    bus.m_axi_bresp  = 2'b00;
    rst = 1'b1;
    step();

    // Single read of 0x100, data returned two cycles after accept
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h100;
    bus.req_size  = 3'd2;
    settle();
    check("rd_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    check("rd_arvalid", bus.m_axi_arvalid, 1);
    check("rd_araddr",  bus.m_axi_araddr, 32'h100);
    check("rd_arsize",  bus.m_axi_arsize, 3'd2);
    check("rd_busy",    bus.idle, 0);
    step();
    check("rd_ar_clear", bus.m_axi_arvalid, 0);
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = 32'hDEAD_BEEF;
    check("rd_not_yet", bus.rd_valid, 0);
    step();
    bus.m_axi_rvalid = 1'b0;
    check("rd_valid",    bus.rd_valid, 1);
    check("rd_data",     bus.rd_data, 32'hDEAD_BEEF);
    check("rd_err",      bus.rd_err, 0);
    step();
    check("rd_pulse",    bus.rd_valid, 0);
    check("rd_hold",     bus.rd_data, 32'hDEAD_BEEF);
    check("rd_idle",     bus.idle, 1);

    // Outstanding limit: four reads, no R
    for (int i = 0; i < MO; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h200 + 32'(4 * i);
      settle();
      check("lim_ready", bus.req_ready, 1);
      step();
    end
    bus.req_addr = 32'h210;
    settle();
    check("lim_full_ready", bus.req_ready, 0);
    check("lim_count",      dut.count_q, 4);
    step();
    check("lim_count_hold", dut.count_q, 4);
    check("lim_ar_drained", bus.m_axi_arvalid, 0);
    bus.req_valid = 1'b0;
    for (int k = 0; k < MO; k++) begin
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = 32'hA0 + 32'(k);
      settle();
      if (k == 0) check("lim_r_ready", bus.req_ready, 1);
      step();
      check("lim_rd_valid", bus.rd_valid, 1);
      check("lim_rd_data",  bus.rd_data, 32'hA0 + 32'(k));
    end
    bus.m_axi_rvalid = 1'b0;
    step();
    check("lim_count_zero", dut.count_q, 0);
    check("lim_idle",       bus.idle, 1);

    // Split write: W accepted at once, AW held off for three cycles
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b1;
    bus.req_valid     = 1'b1;
    bus.req_we        = 1'b1;
    bus.req_addr      = 32'h300;
    bus.req_data      = 32'hCAFE_F00D;
    bus.req_be        = 4'hF;
    settle();
    check("wr_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    check("wr_awvalid1", bus.m_axi_awvalid, 1);
    check("wr_wvalid1",  bus.m_axi_wvalid, 1);
    check("wr_wdata",    bus.m_axi_wdata, 32'hCAFE_F00D);
    check("wr_wstrb",    bus.m_axi_wstrb, 4'hF);
    check("wr_wlast",    bus.m_axi_wlast, 1);
    step();
    check("wr_wvalid2",  bus.m_axi_wvalid, 0);
    check("wr_awvalid2", bus.m_axi_awvalid, 1);
    check("wr_awaddr2",  bus.m_axi_awaddr, 32'h300);
    step();
    check("wr_awvalid3", bus.m_axi_awvalid, 1);
    check("wr_awaddr3",  bus.m_axi_awaddr, 32'h300);
    check("wr_blocked",  bus.req_ready, 0);
    step();
    bus.m_axi_awready = 1'b1;
    settle();
    check("wr_awvalid4", bus.m_axi_awvalid, 1);
    check("wr_awaddr4",  bus.m_axi_awaddr, 32'h300);
    check("wr_aw_drain_ready", bus.req_ready, 1);
    step();
    check("wr_aw_clear", bus.m_axi_awvalid, 0);
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bresp  = 2'b10;
    step();
    bus.m_axi_bvalid = 1'b0;
    bus.m_axi_bresp  = 2'b00;
    check("wr_done", bus.wr_done, 1);
    check("wr_err",  bus.wr_err, 1);
    step();
    check("wr_pulse", bus.wr_done, 0);
    check("wr_idle",  bus.idle, 1);

    // Accept a read together with R and B completions at count 2
    bus.m_axi_arready = 1'b1;
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    bus.req_valid     = 1'b1;
    bus.req_we        = 1'b0;
    bus.req_addr      = 32'h400;
    step();
    bus.req_we   = 1'b1;
    bus.req_addr = 32'h500;
    bus.req_data = 32'h1234_5678;
    bus.req_be   = 4'h3;
    step();
    bus.req_valid = 1'b0;
    step();
    check("sim_count2", dut.count_q, 2);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'h600;
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = 32'h55;
    bus.m_axi_bvalid = 1'b1;
    settle();
    check("sim_ready", bus.req_ready, 1);
    step();
    bus.req_valid    = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_bvalid = 1'b0;
    bus.m_axi_arready = 1'b0;
    check("sim_count1",  dut.count_q, 1);
    check("sim_rd_valid", bus.rd_valid, 1);
    check("sim_rd_data", bus.rd_data, 32'h55);
    check("sim_wr_done", bus.wr_done, 1);
    check("sim_wr_err",  bus.wr_err, 0);
    check("sim_araddr",  bus.m_axi_araddr, 32'h600);
    step();
    check("sim_ar_held", bus.m_axi_arvalid, 1);
    rst = 1'b0;
    settle();
    check("arst_arvalid", bus.m_axi_arvalid, 0);
    check("arst_count",   dut.count_q, 0);
    check("arst_idle",    bus.idle, 1);
    rst = 1'b1;
    step();

    // AR back-pressure with a second request held
    bus.m_axi_arready = 1'b0;
    bus.req_valid     = 1'b1;
    bus.req_we        = 1'b0;
    bus.req_addr      = 32'h700;
    settle();
    check("bp_ready0", bus.req_ready, 1);
    step();
    bus.req_addr = 32'h704;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("bp_arvalid", bus.m_axi_arvalid, 1);
      check("bp_araddr",  bus.m_axi_araddr, 32'h700);
      check("bp_ready",   bus.req_ready, 0);
      step();
    end
    bus.m_axi_arready = 1'b1;
    settle();
    check("bp_release_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    check("bp_reload_valid", bus.m_axi_arvalid, 1);
    check("bp_reload_addr",  bus.m_axi_araddr, 32'h704);
    check("bp_count2",       dut.count_q, 2);
    step();
    check("bp_ar_clear", bus.m_axi_arvalid, 0);
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = 32'h77;
    bus.m_axi_rresp  = 2'b10;
    step();
    check("bp_rd_err1", bus.rd_err, 1);
    check("bp_rd_dat1", bus.rd_data, 32'h77);
    bus.m_axi_rdata = 32'h78;
    bus.m_axi_rresp = 2'b00;
    step();
    bus.m_axi_rvalid = 1'b0;
    check("bp_rd_err2", bus.rd_err, 0);
    check("bp_rd_dat2", bus.rd_data, 32'h78);
    step();
    check("bp_idle", bus.idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
